// File: rtl/rof_pkg.sv
// rof_pkg: shared types and helpers for the rank/mean sliding-window filter.
//   mode_t     : output select (mean, rank-k, min, max)
//   sum_width  : width of a running sum that can never overflow
//   clamp_rank : folds out-of-range rank indices onto the largest cell
package rof_pkg;

  typedef enum logic [1:0] {
    MODE_MEAN = 2'd0,
    MODE_RANK = 2'd1,
    MODE_MIN  = 2'd2,
    MODE_MAX  = 2'd3
  } mode_t;

  // A sum of depth samples of width bits fits in width + clog2(depth+1) bits.
  function automatic int sum_width(input int width, input int depth);
    return width + $clog2(depth + 1);
  endfunction

  // rank_sel is wide enough to name indices past the window; those read the maximum.
  function automatic int clamp_rank(input int rank, input int depth);
    return (rank >= depth) ? depth - 1 : rank;
  endfunction

endpackage

// File: rtl/rof_cell.sv
// rof_cell: one cell of the sorted insertion stack.
//   clk, rst_n  : clock / async active-low reset
//   clear       : synchronous clear to zero (window flush)
//   accept      : a new sample enters the window this cycle
//   expiring    : value leaving the window (one instance gets removed)
//   sample      : value entering the window
//   left_pass   : left neighbour's value after removal (tie to 0 for cell 0)
//   right_val   : right neighbour's stored value (tie to all-ones for the last cell)
//   value       : stored value
//   pass_right  : this position's value after removal, feeds the right neighbour
module rof_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             accept,
  input  logic [WIDTH-1:0] expiring,
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] left_pass,
  input  logic [WIDTH-1:0] right_val,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] pass_right
);

  logic [WIDTH-1:0] stored;
  logic [WIDTH-1:0] next_val;

  // Removing the first instance of the expiring value shifts every cell at or
  // beyond it one place left; cells strictly below it keep their value.
  assign pass_right = (stored < expiring) ? stored : right_val;

  // Insert into the reduced list: keep the reduced value while it is below the
  // sample, take the sample at its slot, and take the left neighbour beyond it.
  always_comb begin
    if (pass_right < sample)
      next_val = pass_right;
    else if (left_pass >= sample)
      next_val = left_pass;
    else
      next_val = sample;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stored <= '0;
    else if (clear)
      stored <= '0;
    else if (accept)
      stored <= next_val;
  end

  assign value = stored;

endmodule

// File: rtl/rank_mean_filt.sv
// rank_mean_filt: sliding-window filter producing mean, rank-k, min or max of
// the DEPTH most recent samples.
//   clk, rst_n : clock / async active-low reset
//   in_valid   : sample qualifier, in_data accepted on the edge
//   in_data    : unsigned sample
//   flush      : synchronous window clear, overrides in_valid
//   mode       : output select (rof_pkg::mode_t)
//   rank_sel   : rank index for MODE_RANK, 0 = smallest, clamped to DEPTH-1
//   out_valid  : one-cycle strobe per accepted sample, two edges later
//   out_data   : filter result
//   primed     : DEPTH samples accepted since reset/flush
module rank_mean_filt
  import rof_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 5,
  localparam int RW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  input  mode_t            mode,
  input  logic [RW-1:0]    rank_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             primed
);

  localparam int SUMW  = sum_width(WIDTH, DEPTH);
  localparam int FILLW = $clog2(DEPTH + 1);

  logic             accept;
  logic [WIDTH-1:0] hist [DEPTH];
  logic [WIDTH-1:0] expiring;
  logic [SUMW-1:0]  sum;
  logic [FILLW-1:0] fill;
  logic             acc_d;
  logic [WIDTH-1:0] cell_val [DEPTH];
  logic [WIDTH-1:0] pass [DEPTH+1];
  logic [WIDTH-1:0] mean_val;
  logic [WIDTH-1:0] rank_val;
  logic [WIDTH-1:0] result;
  int               rank_idx;

  assign accept = in_valid & ~flush;

  // Together with in_data as the newest entry, hist forms a DEPTH+1 long
  // chain; its last register is the sample leaving the window on accept.
  assign expiring = hist[DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (accept) begin
      hist[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  // Running sum stays exact because the expiring value is always part of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sum <= '0;
    else if (flush)
      sum <= '0;
    else if (accept)
      sum <= sum + SUMW'(in_data) - SUMW'(expiring);
  end

  // Fill count saturates at DEPTH; primed rises on the DEPTH-th accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill   <= '0;
      primed <= 1'b0;
    end else if (flush) begin
      fill   <= '0;
      primed <= 1'b0;
    end else if (accept) begin
      if (fill < FILLW'(DEPTH))
        fill <= fill + 1'b1;
      if (fill == FILLW'(DEPTH - 1))
        primed <= 1'b1;
    end
  end

  // Sorted stack, ascending from cell 0. The ends are closed with tie-offs:
  // zero on the left never beats a real insert, all-ones on the right is only
  // reached by the last cell once something to its left has been removed.
  assign pass[0] = '0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [WIDTH-1:0] right_val;
    if (i == DEPTH - 1) begin : g_last
      assign right_val = '1;
    end else begin : g_mid
      assign right_val = cell_val[i+1];
    end
    rof_cell #(.WIDTH(WIDTH)) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (flush),
      .accept     (accept),
      .expiring   (expiring),
      .sample     (in_data),
      .left_pass  (pass[i]),
      .right_val  (right_val),
      .value      (cell_val[i]),
      .pass_right (pass[i+1])
    );
  end

  assign mean_val = WIDTH'(sum / SUMW'(DEPTH));

  // Result select evaluated on the edge after the accept, so mode and
  // rank_sel apply as seen on that edge.
  always_comb begin
    rank_idx = clamp_rank(int'(rank_sel), DEPTH);
    rank_val = cell_val[0];
    for (int i = 0; i < DEPTH; i++)
      if (i == rank_idx) rank_val = cell_val[i];
    case (mode)
      MODE_MEAN: result = mean_val;
      MODE_RANK: result = rank_val;
      MODE_MIN:  result = cell_val[0];
      MODE_MAX:  result = cell_val[DEPTH-1];
      default:   result = mean_val;
    endcase
  end

  // Output stage: a flush also cancels the result still pending from the
  // previous accept, so out_valid stays low for two cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_d     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      acc_d     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      acc_d     <= in_valid;
      out_valid <= acc_d;
      if (acc_d)
        out_data <= result;
    end
  end

endmodule

// File: tb/tb_rank_mean_filt.sv
// tb_rank_mean_filt: scoreboard bench. A window model builds a sorted
// snapshot and sum per accepted sample; outputs are compared when they arrive,
// using the mode/rank_sel seen on the output edge. A second instance
// (WIDTH=16, DEPTH=8) covers full-scale sums and mid-stream reset.
module tb_rank_mean_filt;
  import rof_pkg::*;

  localparam int W   = 8;
  localparam int D   = 5;
  localparam int RW  = $clog2(D);
  localparam int W2  = 16;
  localparam int D2  = 8;
  localparam int RW2 = $clog2(D2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, flush;
  logic [W-1:0]  in_data;
  mode_t         mode;
  logic [RW-1:0] rank_sel;
  logic          out_valid, primed;
  logic [W-1:0]  out_data;

  logic           rst2_n, in_valid2, flush2;
  logic [W2-1:0]  in_data2;
  mode_t          mode2;
  logic [RW2-1:0] rank2;
  logic           out_valid2, primed2;
  logic [W2-1:0]  out_data2;

  rank_mean_filt #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .mode(mode), .rank_sel(rank_sel),
    .out_valid(out_valid), .out_data(out_data), .primed(primed)
  );

  rank_mean_filt #(.WIDTH(W2), .DEPTH(D2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .in_valid(in_valid2), .in_data(in_data2),
    .flush(flush2), .mode(mode2), .rank_sel(rank2),
    .out_valid(out_valid2), .out_data(out_data2), .primed(primed2)
  );

  typedef struct packed {
    logic [D-1:0][W-1:0] s;
    logic [15:0]         sum;
    logic [31:0]         due;
  } snap_t;

  snap_t       sb[$];
  int          win[D];
  int          fill_m;
  bit          prev_acc;
  int          checks = 0;
  int          passes = 0;
  int          cycle = 0;
  mode_t       edge_mode;
  logic [RW-1:0] edge_rank;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Cycle count and the mode/rank the DUT sees on each edge.
  always @(posedge clk) begin
    cycle++;
    edge_mode = mode;
    edge_rank = rank_sel;
  end

  task automatic pushSnap();
    int    tmp[$];
    int    total;
    snap_t sn;
    total = 0;
    for (int i = 0; i < D; i++) begin
      tmp.push_back(win[i]);
      total += win[i];
    end
    tmp.sort();
    for (int i = 0; i < D; i++) sn.s[i] = W'(tmp[i]);
    sn.sum = 16'(total);
    sn.due = 32'(cycle + 2);
    sb.push_back(sn);
  endtask

  // Drives one cycle (inputs change on negedge), updates the model, then
  // checks primed after the edge has been applied.
  task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit f);
    in_valid = v;
    in_data  = d;
    flush    = f;
    if (f) begin
      if (prev_acc) void'(sb.pop_back());
      for (int i = 0; i < D; i++) win[i] = 0;
      fill_m   = 0;
      prev_acc = 1'b0;
    end else if (v) begin
      for (int i = D - 1; i > 0; i--) win[i] = win[i-1];
      win[0] = int'(d);
      if (fill_m < D) fill_m++;
      pushSnap();
      prev_acc = 1'b1;
    end else begin
      prev_acc = 1'b0;
    end
    @(negedge clk);
    checkOutput("primed", 32'(primed), 32'(fill_m >= D));
  endtask

  // Scoreboard monitor for the DEPTH=5 instance.
  always @(negedge clk) begin
    snap_t sn;
    int    exp_v;
    int    idx;
    if (out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_valid", 32'd1, 32'd0);
      end else begin
        sn = sb.pop_front();
        checkOutput("latency", 32'(cycle), sn.due);
        idx = (int'(edge_rank) >= D) ? D - 1 : int'(edge_rank);
        case (edge_mode)
          MODE_MEAN: exp_v = int'(sn.sum) / D;
          MODE_RANK: exp_v = int'(sn.s[idx]);
          MODE_MIN:  exp_v = int'(sn.s[0]);
          default:   exp_v = int'(sn.s[D-1]);
        endcase
        checkOutput("out_data", 32'(out_data), 32'(exp_v));
      end
    end else if (sb.size() > 0 && int'(sb[0].due) <= cycle) begin
      void'(sb.pop_front());
      checkOutput("missing_valid", 32'd0, 32'd1);
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    mode = MODE_MEAN; rank_sel = '0;
    rst2_n = 1'b0; in_valid2 = 1'b0; in_data2 = '0; flush2 = 1'b0;
    mode2 = MODE_MEAN; rank2 = '0;
    for (int i = 0; i < D; i++) win[i] = 0;
    fill_m = 0; prev_acc = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_primed", 32'(primed), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp 1..10 in mean mode: 0,0,1,2,3 while priming, then 4..8.
    mode = MODE_MEAN;
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, W'(i), 1'b0);

    // Steady 10s with one 255 impulse, first through the median then the mean.
    mode = MODE_RANK; rank_sel = 3'd2;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'd10, 1'b0);
    applyStimulus(1'b1, 8'd255, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'd10, 1'b0);
    mode = MODE_MEAN;
    applyStimulus(1'b1, 8'd255, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'd10, 1'b0);

    // Duplicates: window 7,7,7,3,9 then push 7 so a 7 expires.
    mode = MODE_MIN;
    applyStimulus(1'b1, 8'd7, 1'b0);
    applyStimulus(1'b1, 8'd7, 1'b0);
    applyStimulus(1'b1, 8'd7, 1'b0);
    applyStimulus(1'b1, 8'd3, 1'b0);
    applyStimulus(1'b1, 8'd9, 1'b0);
    mode = MODE_MAX;
    applyStimulus(1'b1, 8'd7, 1'b0);
    mode = MODE_MIN;
    applyStimulus(1'b0, 8'd0, 1'b0);
    mode = MODE_RANK; rank_sel = 3'd1;
    applyStimulus(1'b0, 8'd0, 1'b0);

    // Valid gaps with a mode switch in the gap.
    mode = MODE_MEAN;
    applyStimulus(1'b1, 8'd40, 1'b0);
    applyStimulus(1'b0, 8'd99, 1'b0);
    mode = MODE_MAX;
    applyStimulus(1'b0, 8'd98, 1'b0);
    applyStimulus(1'b1, 8'd1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("hold_out_data", 32'(out_data), 32'd40);

    // Flush after 7 samples (in_valid high during flush is ignored), then a
    // zero-filled window read through a clamped rank index.
    mode = MODE_MEAN;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, W'(20 + 3 * i), 1'b0);
    applyStimulus(1'b1, 8'd99, 1'b1);
    mode = MODE_RANK; rank_sel = 3'd7;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, W'(50 + i), 1'b0);
    mode = MODE_RANK; rank_sel = 3'd0;
    applyStimulus(1'b1, 8'd5, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 60; i++) begin
      mode     = mode_t'($urandom_range(0, 3));
      rank_sel = RW'($urandom_range(0, 7));
      applyStimulus(1'(($urandom_range(0, 3)) != 0), W'($urandom_range(0, 255)),
                    1'(($urandom_range(0, 15)) == 0));
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    // Wide instance: full-scale samples, mean must stay 0xFFFF.
    rst2_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      in_valid2 = 1'b1;
      in_data2  = 16'hFFFF;
      @(negedge clk);
      if (i >= D2) begin
        checkOutput("w16_valid", 32'(out_valid2), 32'd1);
        checkOutput("w16_mean", 32'(out_data2), 32'hFFFF);
      end
      checkOutput("w16_primed", 32'(primed2), 32'(i >= D2 - 1));
    end

    // Asynchronous reset mid-stream.
    #2 rst2_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid2), 32'd0);
    checkOutput("async_rst_data", 32'(out_data2), 32'd0);
    checkOutput("async_rst_primed", 32'(primed2), 32'd0);
    @(negedge clk);
    in_valid2 = 1'b0;
    rst2_n    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_valid", 32'(out_valid2), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
